// File: rtl/mmio_console.sv
// Memory-mapped console: byte stores to one word address feed a FIFO drained by an 8N1 serial transmitter.
// Define CONSOLE_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_console #(
  parameter logic [29:0] CONSOLE_WADDR = 30'h2000_0000,
  parameter int          CLKS_PER_BIT  = 16,
  parameter int          FIFO_DEPTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ram_w_enable,
  input  logic [29:0]                 ram_w_addr,
  input  logic [31:0]                 ram_w_val,
  input  logic [3:0]                  ram_w_byte_en,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [2:0]                  dbg_state_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef CONSOLE_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e         state_q;
  logic [15:0]    baud_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           tx_q;
`ifdef CONSOLE_PARITY_EN
  logic           par_q;
`endif
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q;

  logic hit, push, pop, not_empty, baud_last;
  logic [7:0] head;
  logic unused_lanes;

  assign unused_lanes = ^{ram_w_val[31:8], ram_w_byte_en[3:1]};

  assign hit       = ram_w_enable && (ram_w_addr == CONSOLE_WADDR) && ram_w_byte_en[0];
  assign not_empty = (count_q != '0);
  assign baud_last = (baud_q == 16'(CLKS_PER_BIT - 1));
  assign head      = mem_q[rd_ptr_q];
  // The transmitter pops from IDLE or on the last STOP cycle, so frames chain with no gap.
  assign pop       = not_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_last));
  assign push      = hit && ((count_q != CW'(FIFO_DEPTH)) || pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (hit && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= ram_w_val[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef CONSOLE_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= START;
            shift_q <= head;
            baud_q  <= '0;
            tx_q    <= 1'b0;
`ifdef CONSOLE_PARITY_EN
            par_q   <= ^head;
`endif
          end
        end
        START: begin
          if (baud_last) begin
            state_q <= DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q <= '0;
`ifdef CONSOLE_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef CONSOLE_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            state_q <= STOP;
            baud_q  <= '0;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              state_q <= START;
              shift_q <= head;
              tx_q    <= 1'b0;
`ifdef CONSOLE_PARITY_EN
              par_q   <= ^head;
`endif
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx          = tx_q;
  assign busy        = (state_q != IDLE) || not_empty;
  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: directed stores, a serial-line monitor decoding frames against an expected-byte queue.
module tb_mmio_console;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [29:0] WADDR = 30'h2000_0000;
`ifdef CONSOLE_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_w_enable = 1'b0;
  logic [29:0] ram_w_addr = '0;
  logic [31:0] ram_w_val = '0;
  logic [3:0]  ram_w_byte_en = '0;
  logic        tx, busy, fifo_full, overflow;
  logic [2:0]  fifo_count;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int frames_done = 0;
  int frames_aborted = 0;
  logic [7:0] exp_q[$];
  int frame_start[$];

  mmio_console #(
    .CONSOLE_WADDR(WADDR),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ram_w_enable (ram_w_enable),
    .ram_w_addr   (ram_w_addr),
    .ram_w_val    (ram_w_val),
    .ram_w_byte_en(ram_w_byte_en),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic store(input logic [29:0] a, input logic [31:0] v, input logic [3:0] be,
                       input logic en);
    ram_w_enable  = en;
    ram_w_addr    = a;
    ram_w_val     = v;
    ram_w_byte_en = be;
    @(posedge clk); #1;
    ram_w_enable  = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || busy); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", exp_q.size() + int'(busy), 0);
  endtask

  // scoreboard monitor: decode each frame on the line and compare with the expected queue
  initial begin
    logic [FB-1:0] bits;
    logic [7:0]    e;
    bit            aborted;
    int            st;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        bits    = '0;
        bits[0] = tx;
        aborted = 1'b0;
        st      = cyc;
        for (int n = 1; n < FRAME; n++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (n % CPB == CPB / 2) bits[n / CPB] = tx;
        end
        if (aborted) begin
          frames_aborted++;
        end else begin
          frames_done++;
          frame_start.push_back(st);
          chk("frame_start_bit", bits[0], 1'b0);
          chk("frame_stop_bit", bits[FB-1], 1'b1);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got 0x%0h expected no frame", bits[8:1]);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", bits[8:1], e);
`ifdef CONSOLE_PARITY_EN
            chk("frame_parity", bits[9], ^e);
`endif
          end
        end
      end
    end
  end

  initial begin
    int base, done0, abort0;
    bit bad;

    // reset state
    rst_n = 1'b0;
    store(WADDR, 32'h0000_00AA, 4'b0001, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_count", fifo_count, 3'd0);
    chk("reset_full", fifo_full, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single byte 0x41, upper lanes carry junk
    exp_q.push_back(8'h41);
    store(WADDR, 32'hA5A5_A541, 4'b0001, 1'b1);
    chk("hit_count", fifo_count, 3'd1);
    chk("hit_tx_still_idle", tx, 1'b1);
    @(posedge clk); #1;
    chk("tx_fall_latency", tx, 1'b0);
    chk("pop_count", fifo_count, 3'd0);
    repeat (FRAME - 1) @(posedge clk);
    #1;
    chk("busy_last_stop_cycle", busy, 1'b1);
    @(posedge clk); #1;
    chk("busy_after_frame", busy, 1'b0);
    chk("tx_idle_after_frame", tx, 1'b1);

    // non-hits: other address, lane 1 only, strobe low
    store(WADDR + 30'd1, 32'h0000_00FF, 4'b0001, 1'b1);
    store(WADDR, 32'h0000_0055, 4'b0010, 1'b1);
    store(WADDR, 32'h0000_0066, 4'b0001, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_count !== 3'd0) bad = 1'b1;
    end
    chk("miss_no_activity", bad, 1'b0);
    chk("miss_busy", busy, 1'b0);

    // six consecutive hits into a depth-4 FIFO
    base = frame_start.size();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'h10 + 8'(i));
      store(WADDR, 32'h0000_0010 + i, 4'b1111, 1'b1);
    end
    chk("burst_count", fifo_count, 3'd4);
    chk("burst_full", fifo_full, 1'b1);
    chk("burst_overflow", overflow, 1'b1);
    wait_drain(8 * FRAME);
    chk("burst_frames", frame_start.size() - base, 5);
    for (int i = 1; i < 5; i++) begin
      if (base + i < frame_start.size())
        chk("burst_period", frame_start[base + i] - frame_start[base + i - 1], FRAME);
    end
    chk("overflow_sticky", overflow, 1'b1);
    reset_pulse();
    chk("overflow_cleared", overflow, 1'b0);

    // full FIFO with a pop on the same edge as a hit
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      store(WADDR, 32'h0000_0020 + i, 4'b0001, 1'b1);
    end
    chk("fill_count", fifo_count, 3'd4);
    chk("fill_full", fifo_full, 1'b1);
    repeat (FRAME - 4) @(posedge clk);
    #1;
    chk("pre_pop_count", fifo_count, 3'd4);
    exp_q.push_back(8'h25);
    store(WADDR, 32'h0000_0025, 4'b0001, 1'b1);
    chk("pop_push_count", fifo_count, 3'd4);
    chk("pop_push_overflow", overflow, 1'b0);
    chk("pop_push_full", fifo_full, 1'b1);
    wait_drain(8 * FRAME);

    // reset in the middle of data bit 3 with two bytes queued
    done0  = frames_done;
    abort0 = frames_aborted;
    store(WADDR, 32'h0000_0030, 4'b0001, 1'b1);
    store(WADDR, 32'h0000_0031, 4'b0001, 1'b1);
    store(WADDR, 32'h0000_0032, 4'b0001, 1'b1);
    chk("abort_queued", fifo_count, 3'd2);
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    store(WADDR, 32'h0000_0077, 4'b0001, 1'b1);
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", fifo_count, 3'd0);
    chk("abort_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    repeat (3 * FRAME) @(posedge clk);
    #1;
    chk("abort_no_frames", frames_done - done0, 0);
    chk("abort_seen", frames_aborted - abort0, 1);
    chk("abort_tx_idle", tx, 1'b1);

`ifdef CONSOLE_PARITY_EN
    // parity bit: 0x07 has odd weight, 0x03 even
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h03);
    base = frame_start.size();
    store(WADDR, 32'h0000_0007, 4'b0001, 1'b1);
    store(WADDR, 32'h0000_0003, 4'b0001, 1'b1);
    wait_drain(4 * FRAME);
    chk("parity_frames", frame_start.size() - base, 2);
    if (base + 1 < frame_start.size())
      chk("parity_period", frame_start[base + 1] - frame_start[base], 11 * CPB);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
